// File: rtl/picosoc_timer_if.sv
// iomem slave bus between the SoC core and the timer.
// The core drives the request; the timer returns a one-cycle ack and the read data.
interface picosoc_timer_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );
    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/picosoc_timer.sv
// Memory-mapped 32-bit down-counting timer with prescaler, auto-reload / one-shot modes
// and a level interrupt. It decodes a 256-byte window on the iomem bus.
module picosoc_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
    parameter int          PRESCALE_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    picosoc_timer_if.slave   bus,
    output logic             irq
);
    logic [2:0]            ctrl;      // {irq_en, auto_reload, en}
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] pcnt;
    logic [PRESCALE_W-1:0] pre_new;
    logic [31:0]           reload;
    logic [31:0]           count;
    logic                  expired;
    logic [31:0]           pre_ext;
    logic [31:0]           rd_val;
    logic [5:0]            idx;
    logic                  sel, acc, wr, tick, expire;
    logic                  wr_ctrl, wr_pre, wr_reload, wr_count, wr_status;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (strb[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    assign sel = bus.iomem_valid && (bus.iomem_addr[31:8] == BASE_ADDR[31:8]);
    // A request still held in the ack cycle is not taken again.
    assign acc = sel && !bus.iomem_ready;
    assign wr  = acc && (bus.iomem_wstrb != 4'b0000);
    assign idx = bus.iomem_addr[7:2];

    assign wr_ctrl   = wr && (idx == 6'd0);
    assign wr_pre    = wr && (idx == 6'd1);
    assign wr_reload = wr && (idx == 6'd2);
    assign wr_count  = wr && (idx == 6'd3);
    assign wr_status = wr && (idx == 6'd4);

    assign tick   = ctrl[0] && (pcnt == prescale);
    assign expire = tick && (count == 32'd0);
    assign irq    = expired && ctrl[2];

    always_comb begin
        pre_ext = '0;
        pre_ext[PRESCALE_W-1:0] = prescale;
        for (int b = 0; b < PRESCALE_W; b++)
            pre_new[b] = bus.iomem_wstrb[b/8] ? bus.iomem_wdata[b] : prescale[b];
    end

    always_comb begin
        rd_val = '0;
        case (idx)
            6'd0:    rd_val = {29'b0, ctrl};
            6'd1:    rd_val = pre_ext;
            6'd2:    rd_val = reload;
            6'd3:    rd_val = count;
            6'd4:    rd_val = {31'b0, expired};
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.iomem_ready <= 1'b0;
            bus.iomem_rdata <= '0;
            ctrl            <= '0;
            prescale        <= '0;
            pcnt            <= '0;
            reload          <= '0;
            count           <= '0;
            expired         <= 1'b0;
        end else begin
            bus.iomem_ready <= acc;
            bus.iomem_rdata <= acc ? rd_val : 32'd0;

            if (!ctrl[0] || wr_pre || tick) pcnt <= '0;
            else                            pcnt <= pcnt + 1'b1;

            if (wr_pre)    prescale <= pre_new;
            if (wr_reload) reload   <= merge(reload, bus.iomem_wdata, bus.iomem_wstrb);

            // CPU writes take priority over the timer's own updates.
            if (wr_ctrl) begin
                if (bus.iomem_wstrb[0]) ctrl <= bus.iomem_wdata[2:0];
            end else if (expire && !ctrl[1]) begin
                ctrl[0] <= 1'b0;
            end

            if (wr_count) begin
                count <= merge(count, bus.iomem_wdata, bus.iomem_wstrb);
            end else if (tick) begin
                if (count != 32'd0) count <= count - 32'd1;
                else if (ctrl[1])   count <= reload;
            end

            // A hardware set beats a simultaneous write-1-to-clear.
            if (expire)
                expired <= 1'b1;
            else if (wr_status && bus.iomem_wstrb[0] && bus.iomem_wdata[0])
                expired <= 1'b0;
        end
    end
endmodule

// File: tb/tb_picosoc_timer.sv
// Self-checking bench for picosoc_timer: table-driven register vectors feeding a
// read scoreboard, plus hand-written timing, collision and reset sequences.
module tb_picosoc_timer;
    localparam logic [31:0] BASE = 32'h0300_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic irq;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    picosoc_timer_if bus();

    picosoc_timer #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        is_rd;
        logic [31:0] exp;
        string       name;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [7:0]  off;
        logic [3:0]  strb;   // 0 = read
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Every ack pops one scoreboard entry; reads compare rdata, idle cycles expect rdata=0.
    logic prev_rdy = 1'b0;
    always @(posedge clk) begin
        sb_t e;
        #1;
        if (bus.iomem_ready === 1'b1) begin
            chk("ack_single", {31'b0, prev_rdy}, 32'd0);
            if (sbq.size() == 0) chk("spurious_ack", 32'd1, 32'd0);
            else begin
                e = sbq.pop_front();
                if (e.is_rd) chk(e.name, bus.iomem_rdata, e.exp);
            end
        end else begin
            chk("rdata_idle", bus.iomem_rdata, 32'd0);
        end
        prev_rdy = bus.iomem_ready;
    end

    task automatic access(input logic [7:0] off, input logic [3:0] strb, input logic [31:0] wd,
                          input logic [31:0] exp, input string nm, output int lat);
        sb_t e;
        e.is_rd = (strb == 4'b0000);
        e.exp   = exp;
        e.name  = nm;
        sbq.push_back(e);
        @(negedge clk);
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = BASE | {24'b0, off};
        bus.iomem_wstrb = strb;
        bus.iomem_wdata = wd;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (bus.iomem_ready === 1'b1) begin lat = i; break; end
        end
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'b0000;
        if (lat == 0) begin
            chk({nm, "_timeout"}, 32'd0, 32'd1);
            if (sbq.size() > 0) sbq.delete(sbq.size() - 1);
        end
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] wd, input logic [3:0] strb = 4'hF);
        int lat;
        access(off, strb, wd, 32'd0, "wr", lat);
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string nm);
        int lat;
        access(off, 4'b0000, 32'd0, exp, nm, lat);
    endtask

    initial begin
        int lat, rise, n, pulses;
        sb_t e;
        bus.iomem_valid = 1'b0;
        bus.iomem_addr  = '0;
        bus.iomem_wstrb = '0;
        bus.iomem_wdata = '0;

        // register vectors: reset values, strobes, reserved bits, unmapped offsets, W1C
        vt.push_back('{8'h00, 4'h0, 32'h0, 32'h0});
        vt.push_back('{8'h04, 4'h0, 32'h0, 32'h0});
        vt.push_back('{8'h08, 4'h0, 32'h0, 32'h0});
        vt.push_back('{8'h0C, 4'h0, 32'h0, 32'h0});
        vt.push_back('{8'h10, 4'h0, 32'h0, 32'h0});
        vt.push_back('{8'h20, 4'h0, 32'h0, 32'h0});
        vt.push_back('{8'h08, 4'b0101, 32'hAABBCCDD, 32'h0});
        vt.push_back('{8'h08, 4'h0, 32'h0, 32'h00BB00DD});
        vt.push_back('{8'h00, 4'b0001, 32'h000000FF, 32'h0});
        vt.push_back('{8'h00, 4'h0, 32'h0, 32'h7});
        vt.push_back('{8'h00, 4'hF, 32'h0, 32'h0});
        vt.push_back('{8'h00, 4'hF, 32'hFFFFFFF8, 32'h0});
        vt.push_back('{8'h00, 4'h0, 32'h0, 32'h0});
        vt.push_back('{8'h04, 4'hF, 32'h12345678, 32'h0});
        vt.push_back('{8'h04, 4'h0, 32'h0, 32'h00005678});
        vt.push_back('{8'h14, 4'hF, 32'hFFFFFFFF, 32'h0});
        vt.push_back('{8'h14, 4'h0, 32'h0, 32'h0});
        vt.push_back('{8'h0C, 4'hF, 32'h0, 32'h0});
        vt.push_back('{8'h0C, 4'b1010, 32'h11223344, 32'h0});
        vt.push_back('{8'h0C, 4'h0, 32'h0, 32'h11003300});
        vt.push_back('{8'h10, 4'h0, 32'h0, 32'h1});
        vt.push_back('{8'h10, 4'hF, 32'h0, 32'h0});
        vt.push_back('{8'h10, 4'h0, 32'h0, 32'h1});
        vt.push_back('{8'h10, 4'h1, 32'h1, 32'h0});
        vt.push_back('{8'h10, 4'h0, 32'h0, 32'h0});

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, bus.iomem_ready}, 32'd0);
        chk("rst_rdata", bus.iomem_rdata, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            @(posedge clk);
            access(vt[i].off, vt[i].strb, vt[i].wdata, vt[i].exp, $sformatf("vec%0d", i), lat);
            chk($sformatf("vec%0d_lat", i), lat, 32'd1);
        end

        // outside the window: no ack
        @(negedge clk);
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = 32'h0200_0004;
        bus.iomem_wstrb = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("no_ack_outside", {31'b0, bus.iomem_ready}, 32'd0);
        end
        bus.iomem_valid = 1'b0;

        // held request: acks on alternate cycles only
        e.is_rd = 1'b1; e.exp = 32'h00BB00DD; e.name = "held_rd";
        sbq.push_back(e);
        sbq.push_back(e);
        @(negedge clk);
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = BASE | 32'h08;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.iomem_ready === 1'b1) pulses++;
        end
        bus.iomem_valid = 1'b0;
        chk("held_pulses", pulses, 32'd2);

        // periodic: (3+1)*(1+1) = 8 cycles
        wr(8'h00, 32'h0); wr(8'h10, 32'h1);
        wr(8'h08, 32'd3); wr(8'h04, 32'd1); wr(8'h0C, 32'd3); wr(8'h00, 32'h7);
        rise = cyc;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (irq === 1'b1) begin n = i; break; end
        end
        chk("irq_first", n, 32'd8);
        for (int k = 0; k < 2; k++) begin
            rise = cyc;
            wr(8'h10, 32'h1);
            chk("irq_w1c", {31'b0, irq}, 32'd0);
            n = 0;
            for (int i = 0; i < 20; i++) begin
                if (irq === 1'b1) begin n = cyc - rise; break; end
                @(posedge clk); #1;
            end
            chk("irq_period", n, 32'd8);
        end

        // COUNT at 2-cycle read steps
        wr(8'h00, 32'h0); wr(8'h10, 32'h1); wr(8'h0C, 32'd3); wr(8'h00, 32'h3);
        rd(8'h0C, 32'd3, "cnt_seq0");
        rd(8'h0C, 32'd2, "cnt_seq1");
        rd(8'h0C, 32'd1, "cnt_seq2");
        rd(8'h0C, 32'd0, "cnt_seq3");
        rd(8'h0C, 32'd3, "cnt_seq4");

        // one-shot
        wr(8'h00, 32'h0); wr(8'h10, 32'h1);
        wr(8'h04, 32'd0); wr(8'h0C, 32'd2); wr(8'h00, 32'h5);
        repeat (6) @(posedge clk);
        rd(8'h10, 32'h1, "os_status");
        rd(8'h00, 32'h4, "os_ctrl");
        rd(8'h0C, 32'h0, "os_count");
        chk("os_irq", {31'b0, irq}, 32'd1);
        repeat (20) @(posedge clk);
        rd(8'h0C, 32'h0, "os_count_hold");

        // COUNT write on a tick cycle (tick lands 8 edges after the CTRL commit)
        wr(8'h00, 32'h0); wr(8'h10, 32'h1);
        wr(8'h08, 32'h10); wr(8'h04, 32'd7); wr(8'h0C, 32'h50); wr(8'h00, 32'h3);
        repeat (7) @(posedge clk);
        wr(8'h0C, 32'h100);
        rd(8'h0C, 32'h100, "col_count");

        // W1C on the cycle expired sets
        wr(8'h00, 32'h0); wr(8'h10, 32'h1);
        wr(8'h0C, 32'h0); wr(8'h00, 32'h3);
        repeat (7) @(posedge clk);
        wr(8'h10, 32'h1);
        rd(8'h10, 32'h1, "col_w1c");
        chk("irq_gated", {31'b0, irq}, 32'd0);
        wr(8'h00, 32'h0); wr(8'h10, 32'h1);
        rd(8'h10, 32'h0, "w1c_plain");

        // async reset mid-access with irq high
        wr(8'h04, 32'd0); wr(8'h08, 32'h1000); wr(8'h0C, 32'h0); wr(8'h00, 32'h7);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_irq", {31'b0, irq}, 32'd1);
        e.is_rd = 1'b0; e.exp = 32'h0; e.name = "rst_acc";
        sbq.push_back(e);
        @(negedge clk);
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = BASE | 32'h0C;
        bus.iomem_wstrb = 4'b0000;
        @(posedge clk); #1;
        chk("pre_rst_ready", {31'b0, bus.iomem_ready}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("async_ready", {31'b0, bus.iomem_ready}, 32'd0);
        chk("async_irq", {31'b0, irq}, 32'd0);
        chk("async_rdata", bus.iomem_rdata, 32'd0);
        chk("async_count", dut.count, 32'd0);
        bus.iomem_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_irq", {31'b0, irq}, 32'd0);
        rd(8'h0C, 32'h0, "post_rst_count");
        rd(8'h00, 32'h0, "post_rst_ctrl");
        rd(8'h10, 32'h0, "post_rst_status");
        repeat (2) @(posedge clk);
        chk("sb_empty", sbq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
